// File: rtl/wallace_mac_accum_pkg.sv
// wallace_mac_accum_pkg: shared state encoding and default widths for the MAC accumulator
package mac_pkg;
    localparam int PROD_W = 32;
    localparam int ACC_W  = 40;
    localparam int LEN_W  = 8;
    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
endpackage

// File: rtl/wallace_mac_accum_if.sv
// wallace_mac_accum_if: burst control, product stream and sum handshake of the accumulator
interface wallace_mac_accum_if #(
    parameter int PROD_W = mac_pkg::PROD_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int LEN_W  = mac_pkg::LEN_W
);
    logic              start;
    logic [LEN_W-1:0]  len;
    logic              prod_valid;
    logic [PROD_W-1:0] prod_data;
    logic              prod_ready;
    logic              sum_valid;
    logic              sum_ready;
    logic [ACC_W-1:0]  sum_data;
    logic              sum_ovf;
    logic              busy;
    modport master (
        output start, len, prod_valid, prod_data, sum_ready,
        input  prod_ready, sum_valid, sum_data, sum_ovf, busy
    );
    modport slave (
        input  start, len, prod_valid, prod_data, sum_ready,
        output prod_ready, sum_valid, sum_data, sum_ovf, busy
    );
endinterface

// File: rtl/wallace_mac_accum.sv
// wallace_mac_accum: accumulates a burst of unsigned products and hands the sum off
// through a one-deep valid/ready register with a sticky carry-out flag.
module wallace_mac_accum import mac_pkg::*; #(
    parameter int PROD_W = mac_pkg::PROD_W,
    parameter int ACC_W  = mac_pkg::ACC_W,
    parameter int LEN_W  = mac_pkg::LEN_W
) (
    input logic clk,
    input logic rst_n,
    wallace_mac_accum_if.slave bus
);
    state_t             state, state_d;
    logic [ACC_W-1:0]   acc, sum_q;
    logic [LEN_W-1:0]   cnt, len_q;
    logic               ovf, ovf_q;
    logic [ACC_W:0]     sum;
    logic               beat, last;
    assign sum  = {1'b0, acc} + (ACC_W+1)'(bus.prod_data);
    assign beat = state == ACCUM && bus.prod_valid;
    assign last = beat && cnt == len_q - 1'b1;
    always_comb begin
        state_d = (state == IDLE && bus.start) ? (bus.len != '0 ? ACCUM : DONE)
                : last                         ? DONE
                : (state == DONE && bus.sum_ready) ? IDLE
                : state;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc   <= '0;
            cnt   <= '0;
            len_q <= '0;
            ovf   <= 1'b0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            if (state == IDLE && bus.start) begin
                if (bus.len != '0) begin
                    len_q <= bus.len;
                    acc   <= '0;
                    cnt   <= '0;
                    ovf   <= 1'b0;
                end else begin
                    sum_q <= '0;
                    ovf_q <= 1'b0;
                end
            end
            if (beat) begin
                acc <= sum[ACC_W-1:0];
                cnt <= cnt + 1'b1;
                ovf <= ovf | sum[ACC_W];
                if (last) begin
                    sum_q <= sum[ACC_W-1:0];
                    ovf_q <= ovf | sum[ACC_W];
                end
            end
        end
    end
    assign bus.prod_ready = state == ACCUM;
    assign bus.sum_valid  = state == DONE;
    assign bus.busy       = state != IDLE;
    assign bus.sum_data   = sum_q;
    assign bus.sum_ovf    = ovf_q;
endmodule

// File: tb/tb_wallace_mac_accum.sv
// tb_wallace_mac_accum: drives a 40-bit and a 32-bit accumulator with identical bursts
// and checks both against an arithmetic reference of the burst sum.
module tb_wallace_mac_accum;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  len = '0;
    logic        prod_valid = 1'b0;
    logic [31:0] prod_data = '0;
    logic        sum_ready = 1'b0;
    int          errors = 0;
    int          checks = 0;
    logic [31:0] prods[$];

    always #5 clk = ~clk;

    wallace_mac_accum_if #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) ia ();
    wallace_mac_accum_if #(.PROD_W(32), .ACC_W(32), .LEN_W(8)) ib ();

    assign ia.start = start;
    assign ia.len = len;
    assign ia.prod_valid = prod_valid;
    assign ia.prod_data = prod_data;
    assign ia.sum_ready = sum_ready;
    assign ib.start = start;
    assign ib.len = len;
    assign ib.prod_valid = prod_valid;
    assign ib.prod_data = prod_data;
    assign ib.sum_ready = sum_ready;

    wallace_mac_accum #(.PROD_W(32), .ACC_W(40), .LEN_W(8)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
    wallace_mac_accum #(.PROD_W(32), .ACC_W(32), .LEN_W(8)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

    // Sum of the queued products modulo 2^w, flagging any step that exceeded w bits.
    function automatic void model(input int w, output logic [63:0] s, output logic o);
        s = '0;
        o = 1'b0;
        foreach (prods[i]) begin
            s += 64'(prods[i]);
            if ((s >> w) != 64'd0) begin
                o = 1'b1;
                s &= (64'd1 << w) - 64'd1;
            end
        end
    endfunction

    task automatic check_idle(input string tag);
        checks++;
        if ({ia.prod_ready, ia.sum_valid, ia.busy} !== 3'b000 || {ib.prod_ready, ib.sum_valid, ib.busy} !== 3'b000) begin
            errors++;
            $display("FAIL %s idle flags: got a=%b%b%b b=%b%b%b expected 000", tag,
                     ia.prod_ready, ia.sum_valid, ia.busy, ib.prod_ready, ib.sum_valid, ib.busy);
        end
    endtask

    // Called at a negedge with both DUTs idle; runs one burst of the queued products.
    task automatic burst(input string tag, input int gap, input int hold);
        logic [63:0] ea, eb;
        logic        oa, ob;
        model(40, ea, oa);
        model(32, eb, ob);
        start = 1'b1;
        len = 8'(prods.size());
        @(negedge clk);
        start = 1'b0;
        foreach (prods[i]) begin
            repeat (gap) begin
                checks++;
                if (ia.prod_ready !== 1'b1 || ia.sum_valid !== 1'b0 || ia.busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s stall beat %0d: got ready=%b valid=%b busy=%b expected 1 0 1",
                             tag, i, ia.prod_ready, ia.sum_valid, ia.busy);
                end
                @(negedge clk);
            end
            checks++;
            if (ia.prod_ready !== 1'b1 || ib.prod_ready !== 1'b1 || ia.sum_valid !== 1'b0) begin
                errors++;
                $display("FAIL %s ready beat %0d: got a=%b b=%b valid=%b expected 1 1 0",
                         tag, i, ia.prod_ready, ib.prod_ready, ia.sum_valid);
            end
            prod_valid = 1'b1;
            prod_data = prods[i];
            @(negedge clk);
            prod_valid = 1'b0;
        end
        for (int h = 0; h <= hold; h++) begin
            checks++;
            if (ia.sum_valid !== 1'b1 || ib.sum_valid !== 1'b1 || ia.prod_ready !== 1'b0 || ia.busy !== 1'b1) begin
                errors++;
                $display("FAIL %s done flags cycle %0d: got valid=%b/%b ready=%b busy=%b expected 1/1 0 1",
                         tag, h, ia.sum_valid, ib.sum_valid, ia.prod_ready, ia.busy);
            end
            checks++;
            if (ia.sum_data !== ea[39:0] || ia.sum_ovf !== oa) begin
                errors++;
                $display("FAIL %s sum40 cycle %0d: got %0d ovf=%b expected %0d ovf=%b",
                         tag, h, ia.sum_data, ia.sum_ovf, ea[39:0], oa);
            end
            checks++;
            if (ib.sum_data !== eb[31:0] || ib.sum_ovf !== ob) begin
                errors++;
                $display("FAIL %s sum32 cycle %0d: got %0d ovf=%b expected %0d ovf=%b",
                         tag, h, ib.sum_data, ib.sum_ovf, eb[31:0], ob);
            end
            start = 1'b1;
            len = 8'd3;
            sum_ready = h == hold;
            @(negedge clk);
        end
        sum_ready = 1'b0;
        check_idle({tag, " handoff"});
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_idle("reset");
        checks++;
        if (ia.sum_data !== 40'd0 || ia.sum_ovf !== 1'b0 || ib.sum_data !== 32'd0 || ib.sum_ovf !== 1'b0) begin
            errors++;
            $display("FAIL reset sum: got %0d/%b %0d/%b expected 0", ia.sum_data, ia.sum_ovf, ib.sum_data, ib.sum_ovf);
        end
    endtask

    task automatic test_basic();
        prods = '{32'd1743104, 32'd101727396, 32'd1743104};
        burst("basic", 0, 0);
    endtask

    task automatic test_stall_backpressure();
        prods = '{32'd4294836225, 32'd4294836225};
        burst("stall", 3, 5);
    endtask

    task automatic test_zero_len();
        prods = {};
        burst("zero", 0, 0);
        prods = '{32'd7};
        burst("len1", 0, 0);
    endtask

    task automatic test_overflow();
        prods = '{32'd4294836225, 32'd4294836225};
        burst("ovf", 0, 0);
        prods = '{32'd5};
        burst("ovf_clear", 0, 0);
    endtask

    task automatic test_abort();
        start = 1'b1;
        len = 8'd4;
        @(negedge clk);
        start = 1'b0;
        prod_valid = 1'b1;
        prod_data = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        prod_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_idle("abort");
        checks++;
        if (ia.sum_data !== 40'd0 || ib.sum_data !== 32'd0 || ia.sum_ovf !== 1'b0) begin
            errors++;
            $display("FAIL abort sum: got %0d %0d ovf=%b expected 0", ia.sum_data, ib.sum_data, ia.sum_ovf);
        end
        @(negedge clk);
        rst_n = 1'b1;
        prods = '{32'd9};
        burst("after_abort", 0, 0);
    endtask

    task automatic test_random();
        for (int r = 0; r < 20; r++) begin
            prods = {};
            repeat ($urandom_range(0, 6)) prods.push_back($urandom);
            burst($sformatf("rand%0d", r), $urandom_range(0, 2), $urandom_range(0, 2));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall_backpressure();
        test_zero_len();
        test_overflow();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
